// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for pipeline stage registers (IF/ID, ID/EX,
//               EX/MEM, MEM/WB): occupancy state encoding and default widths.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

    // Default control bundle width: ALU select, WB, mem-write, load, extend.
    localparam int unsigned c_ctrl_w_dflt = 8;
    // Default payload width: operands, store data, register indices.
    localparam int unsigned c_data_w_dflt = 111;
    // Width of the bubble statistics counter.
    localparam int unsigned c_bubble_w    = 16;

    // Stage occupancy: no beat, main slot only, main plus skid slot.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_reg
// Description : Valid/ready pipeline stage register with optional two-entry
//               skid buffer, flush, and a saturating bubble counter. The
//               control bundle is masked to zero whenever no beat is held.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int unsigned CTRL_W = c_ctrl_w_dflt,
    parameter int unsigned DATA_W = c_data_w_dflt,
    parameter int unsigned SKID   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CTRL_W-1:0]     in_ctrl,
    input  logic [DATA_W-1:0]     in_data,
    input  logic                  flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CTRL_W-1:0]     out_ctrl,
    output logic [DATA_W-1:0]     out_data,
    output logic [c_bubble_w-1:0] bubble_cnt
);

    localparam logic c_skid_en = (SKID != 0);
    localparam logic [c_bubble_w-1:0] c_bubble_max = '1;

    pipe_state_e          r_state;
    pipe_state_e          w_state_nxt;
    logic [CTRL_W-1:0]    r_main_ctrl;
    logic [DATA_W-1:0]    r_main_data;
    logic [CTRL_W-1:0]    r_skid_ctrl;
    logic [DATA_W-1:0]    r_skid_data;
    logic [c_bubble_w-1:0] r_bubble_cnt;

    logic w_out_valid;
    logic w_in_ready;
    logic w_accept;
    logic w_consume;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_out_valid = (r_state != EMPTY);
    assign w_accept    = in_valid & w_in_ready & ~flush;
    assign w_consume   = w_out_valid & out_ready;

    // Next occupancy state and slot load enables; flush overrides everything.
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt    = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_accept && w_consume) begin
                        w_load_main_in = 1'b1;
                    end else if (w_consume) begin
                        w_state_nxt = EMPTY;
                    end else if (w_accept && c_skid_en) begin
                        // Downstream stalled: park the new beat behind the held one.
                        w_state_nxt = FULL;
                        w_load_skid = 1'b1;
                    end
                end
                FULL: begin
                    if (w_consume) begin
                        w_state_nxt      = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    // Occupancy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Main slot: loads from the input or from the skid slot, never on flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_main_ctrl <= '0;
            r_main_data <= '0;
        end else if (w_load_main_in) begin
            r_main_ctrl <= in_ctrl;
            r_main_data <= in_data;
        end else if (w_load_main_skid) begin
            r_main_ctrl <= r_skid_ctrl;
            r_main_data <= r_skid_data;
        end
    end

    // Skid slot: captures a beat accepted while the main slot is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
        end else if (w_load_skid) begin
            r_skid_ctrl <= in_ctrl;
            r_skid_data <= in_data;
        end
    end

    // Saturating count of cycles with no beat presented downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bubble_cnt <= '0;
        end else if (!w_out_valid && (r_bubble_cnt != c_bubble_max)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    generate
        if (SKID != 0) begin : g_skid_ready
            logic r_in_ready;

            // Registered ready breaks the out_ready -> in_ready timing path.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_in_ready <= 1'b1;
                end else begin
                    r_in_ready <= (w_state_nxt != FULL);
                end
            end

            assign w_in_ready = r_in_ready;
        end else begin : g_comb_ready
            assign w_in_ready = ~w_out_valid | out_ready;
        end
    endgenerate

    assign in_ready   = w_in_ready;
    assign out_valid  = w_out_valid;
    assign out_ctrl   = w_out_valid ? r_main_ctrl : '0;
    assign out_data   = r_main_data;
    assign bubble_cnt = r_bubble_cnt;

endmodule : pipe_stage_reg
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg, SKID=1 and SKID=0
//               instances sharing one stimulus stream, each with its own
//               scoreboard of accepted beats.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

    localparam int unsigned CW = 8;
    localparam int unsigned DW = 111;

    typedef struct {
        logic [CW-1:0] c;
        logic [DW-1:0] d;
    } beat_t;

    typedef struct {
        logic          v;
        logic [CW-1:0] c;
        logic          r;
        logic          f;
        logic          e_ov;
        logic [CW-1:0] e_oc;
        logic          e_ir;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [CW-1:0] in_ctrl;
    logic [DW-1:0] in_data;
    logic          flush;
    logic          out_ready;

    logic          ir1, ov1, ir0, ov0;
    logic [CW-1:0] oc1, oc0;
    logic [DW-1:0] od1, od0;
    logic [15:0]   bc1, bc0;

    beat_t q1[$];
    beat_t q0[$];
    int    cons1 = 0;
    int    cons0 = 0;
    int    n_chk = 0;
    int    n_err = 0;

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(ov1), .out_ready(out_ready), .out_ctrl(oc1),
        .out_data(od1), .bubble_cnt(bc1)
    );

    pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .in_ctrl(in_ctrl), .in_data(in_data), .flush(flush),
        .out_valid(ov0), .out_ready(out_ready), .out_ctrl(oc0),
        .out_data(od0), .bubble_cnt(bc0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mkd(input logic [CW-1:0] c);
        logic [31:0] t;
        t = {c, ~c, c ^ 8'hA5, c};
        return {t, t, t, t[14:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [CW-1:0] c, input logic r, input logic f);
        in_valid  = v;
        in_ctrl   = c;
        in_data   = mkd(c);
        out_ready = r;
        flush     = f;
    endtask

    task automatic drain();
        drv(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (4) tick();
    endtask

    // Scoreboard: check the state left by the last edge, then model the next edge.
    always @(negedge clk) begin
        beat_t b;
        if (rst_n) begin
            chk("ov1", ov1, q1.size() != 0);
            if (q1.size() != 0) begin
                chk("oc1", oc1, q1[0].c);
                chk("od1", od1, q1[0].d);
            end else begin
                chk("oc1_zero", oc1, 0);
            end
            chk("ir1", ir1, q1.size() < 2);
            chk("ov0", ov0, q0.size() != 0);
            if (q0.size() != 0) begin
                chk("oc0", oc0, q0[0].c);
                chk("od0", od0, q0[0].d);
            end else begin
                chk("oc0_zero", oc0, 0);
            end
            chk("ir0", ir0, (q0.size() == 0) || out_ready);
            chk("occ0", q0.size() <= 1, 1);
            b.c = in_ctrl;
            b.d = in_data;
            if (flush) begin
                q1.delete();
                q0.delete();
            end else begin
                if (q1.size() != 0 && out_ready) begin
                    void'(q1.pop_front());
                    cons1++;
                end
                if (in_valid && ir1) q1.push_back(b);
                if (q0.size() != 0 && out_ready) begin
                    void'(q0.pop_front());
                    cons0++;
                end
                if (in_valid && ir0) q0.push_back(b);
            end
        end else begin
            q1.delete();
            q0.delete();
        end
    end

    initial begin
        vec_t vt[10];
        int   c1;
        int   c0;
        int   sent;
        logic acc;

        vt[0] = '{1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b1};
        vt[1] = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b1, 8'h11, 1'b1};
        vt[2] = '{1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
        vt[3] = '{1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h11, 1'b0};
        vt[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h22, 1'b1};
        vt[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1};
        vt[6] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        vt[7] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b1};
        vt[8] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        vt[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1};

        // Reset values, then first beat on the first edge after release.
        rst_n = 1'b0;
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        chk("rst_ov1", ov1, 0);
        chk("rst_oc1", oc1, 0);
        chk("rst_od1", od1, 0);
        chk("rst_bc1", bc1, 0);
        chk("rst_ir1", ir1, 1);
        chk("rst_ov0", ov0, 0);
        chk("rst_bc0", bc0, 0);
        #1 rst_n = 1'b1;
        drv(1'b1, 8'h5A, 1'b1, 1'b0);
        tick();
        chk("first_ov1", ov1, 1);
        chk("first_oc1", oc1, 8'h5A);
        chk("first_ov0", ov0, 1);
        chk("first_oc0", oc0, 8'h5A);
        chk("first_bc1", bc1, 1);
        for (int i = 0; i < 20; i++) begin
            drv(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0);
            tick();
        end
        chk("stream_bc1", bc1, 1);
        chk("stream_bc0", bc0, 1);
        drain();

        // Table of single-cycle transitions for the skid instance.
        for (int i = 0; i < 10; i++) begin
            drv(vt[i].v, vt[i].c, vt[i].r, vt[i].f);
            tick();
            chk($sformatf("vec%0d_ov", i), ov1, vt[i].e_ov);
            chk($sformatf("vec%0d_oc", i), oc1, vt[i].e_oc);
            chk($sformatf("vec%0d_ir", i), ir1, vt[i].e_ir);
        end
        drain();

        // A, B, C against a stalled sink: fills, then drains in order.
        c1 = cons1;
        drv(1'b1, 8'hA1, 1'b0, 1'b0);
        tick();
        drv(1'b1, 8'hB2, 1'b0, 1'b0);
        tick();
        chk("full_ir1", ir1, 0);
        drv(1'b1, 8'hC3, 1'b0, 1'b0);
        repeat (2) tick();
        chk("stall_ir1", ir1, 0);
        chk("stall_oc1", oc1, 8'hA1);
        out_ready = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) begin
            acc = ir1;
            tick();
        end
        chk("c_accept_timeout", acc, 1);
        drain();
        chk("abc_count", cons1 - c1, 3);

        // Flush while full with D offered: D must never appear.
        drv(1'b1, 8'hA1, 1'b0, 1'b0);
        tick();
        drv(1'b1, 8'hB2, 1'b0, 1'b0);
        tick();
        chk("pre_flush_ir1", ir1, 0);
        drv(1'b1, 8'hD4, 1'b0, 1'b1);
        tick();
        chk("flush_ov1", ov1, 0);
        chk("flush_oc1", oc1, 0);
        chk("flush_ir1", ir1, 1);
        drv(1'b0, 8'h00, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_flush_ov1", ov1, 0);
        end
        drain();

        // Asynchronous reset between edges while one beat is held.
        drv(1'b1, 8'hE5, 1'b0, 1'b0);
        tick();
        chk("pre_rst_ov1", ov1, 1);
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ov1", ov1, 0);
        chk("arst_oc1", oc1, 0);
        chk("arst_od1", od1, 0);
        chk("arst_ir1", ir1, 1);
        chk("arst_ov0", ov0, 0);
        chk("arst_bc1", bc1, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        chk("rel_bc1", bc1, 0);
        chk("rel_ov1", ov1, 0);
        drv(1'b1, 8'hF6, 1'b1, 1'b0);
        tick();
        chk("rel_first_ov1", ov1, 1);
        chk("rel_first_oc1", oc1, 8'hF6);
        chk("rel_first_oc0", oc0, 8'hF6);
        drain();

        // Toggling sink with continuous offers: no beat lost in either mode.
        c0 = cons0;
        sent = 0;
        for (int i = 0; i < 200 && sent < 16; i++) begin
            drv(1'b1, 8'h80 + 8'(sent), (i % 2) == 0, 1'b0);
            #1;
            acc = ir0;
            tick();
            if (acc) sent++;
        end
        chk("toggle_timeout", sent, 16);
        drain();
        chk("toggle_count0", cons0 - c0, 16);
        chk("drained_q1", q1.size(), 0);
        chk("drained_q0", q0.size(), 0);

        // Long idle: bubble counter counts, then saturates without wrapping.
        rst_n = 1'b0;
        drv(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        #1 rst_n = 1'b1;
        repeat (100) tick();
        chk("bc1_100", bc1, 100);
        chk("bc0_100", bc0, 100);
        repeat (69900) tick();
        chk("bc1_sat", bc1, 16'hFFFF);
        chk("bc0_sat", bc0, 16'hFFFF);
        repeat (5) tick();
        chk("bc1_hold", bc1, 16'hFFFF);
        chk("bc0_hold", bc0, 16'hFFFF);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule : tb_pipe_stage_reg
`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 8, SHALL set the width of the control bundle (ALU select, WB, mem-write, load, extend flags), which is zeroed on bubbles.
REQ-002 Parameter DATA_W, default 111, SHALL set the width of the payload bundle (operands, store data, register indices), which is never cleared by flush.
REQ-003 Parameter SKID, default 1, SHALL select the buffering mode: 1 = two-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready.
REQ-004 clk  input  1  Sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  Reset, asynchronous and active-low.
REQ-006 in_valid  input  1  Upstream stage offers a beat.
REQ-007 in_ready  output  1  Stage accepts the offered beat this cycle.
REQ-008 in_ctrl  input  CTRL_W  Control bundle of the offered beat.
REQ-009 in_data  input  DATA_W  Payload bundle of the offered beat.
REQ-010 flush  input  1  Synchronous squash of all held and incoming beats (branch or hazard kill).
REQ-011 out_valid  output  1  Held beat presented downstream.
REQ-012 out_ready  input  1  Downstream consumes the presented beat.
REQ-013 out_ctrl  output  CTRL_W  Control bundle of the presented beat; all-zero whenever out_valid=0.
REQ-014 out_data  output  DATA_W  Payload bundle of the presented beat.
REQ-015 bubble_cnt  output  16  Saturating count of cycles with out_valid=0 since reset.

Function
REQ-016 A beat SHALL be accepted on a rising edge when in_valid=1, in_ready=1 and flush=0; it SHALL be consumed when out_valid=1 and out_ready=1.
REQ-017 Latency SHALL be 1 cycle: a beat accepted while the stage is EMPTY appears on out_* in the next cycle.
REQ-018 With SKID=1, the state machine SHALL be EMPTY -> ONE on accept; ONE -> ONE on simultaneous accept+consume; ONE -> EMPTY on consume only; ONE -> FULL on accept without consume (beat parked in the skid slot); FULL -> ONE on consume (skid beat promoted to the main slot).
REQ-019 With SKID=1, in_ready SHALL be a flop equal to (next state != FULL); no combinational path from out_ready to in_ready SHALL exist.
REQ-020 With SKID=0, in_ready SHALL equal (!out_valid || out_ready), FULL SHALL be unreachable, and accept+consume in the same cycle SHALL replace the held beat.
REQ-021 Beats SHALL leave the stage in acceptance order; none SHALL be duplicated or dropped except by flush.
REQ-022 While out_valid=1 and out_ready=0, out_ctrl and out_data SHALL hold stable.
REQ-023 flush=1 SHALL force the next state to EMPTY, clear both valid bits, drive out_ctrl to zero and in_ready to 1 in the next cycle, and discard any beat offered in the same cycle; flush SHALL take priority over simultaneous accept and consume.
REQ-024 Data registers SHALL load only on accept or promotion, never on flush.
REQ-025 bubble_cnt SHALL increment each cycle in which out_valid=0 and SHALL saturate at 16'hFFFF.

Reset
REQ-026 While rst_n=0: state EMPTY, out_valid=0, out_ctrl=0, out_data=0, skid slot cleared, bubble_cnt=0, in_ready=1 (SKID=1).
REQ-027 Reset assertion mid-operation SHALL discard all held beats immediately, regardless of clk.
REQ-028 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 Package pipe_pkg SHALL hold the state enumeration (EMPTY, ONE, FULL) and the default CTRL_W and DATA_W constants shared by the IF/ID, ID/EX, EX/MEM and MEM/WB instances.
REQ-030 No sub-module SHALL be used: main slot, skid slot and state logic reside in pipe_stage_reg.

Verification
REQ-031 Reset, then in_valid=1 with ctrl=8'h5A and data=A, out_ready=1 -> out_valid=1 and ctrl=8'h5A on the next cycle; zero bubbles in steady streaming.
REQ-032 Stream beats A, B, C with out_ready=0 for 2 cycles (SKID=1) -> state FULL, in_ready=0; after release, outputs A, B, C in order with none lost.
REQ-033 Assert flush while FULL and in_valid=1 (beat D) -> next cycle out_valid=0, out_ctrl=0, in_ready=1; D never appears at the output.
REQ-034 Drop rst_n asynchronously between edges while ONE -> out_valid falls immediately; after release, bubble_cnt=0 and state EMPTY.
REQ-035 SKID=0, out_ready toggling each cycle with continuous in_valid -> in_ready tracks (!out_valid || out_ready) in the same cycle and no beat is lost.
REQ-036 Hold in_valid=0 for 70000 cycles -> bubble_cnt saturates at 16'hFFFF and does not wrap.
